// File: rtl/inst_fetch_queue_if.sv
// Bus bundle for the instruction fetch queue: the memory read channel and the
// datapath delivery channel.
//
// Handshakes:
//   memory   : mem_req is held high with a stable mem_addr until the one-cycle
//              mem_ack pulse returns mem_rdata; a request is never withdrawn.
//   datapath : inst_valid/inst_ready. A head entry transfers on a rising edge
//              where both are high and redirect is low; inst_out/inst_pc are
//              meaningful only while inst_valid is high.
interface inst_fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  // Fetch queue side.
  modport master (
    output mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );

  // Memory and datapath side.
  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_out, inst_pc,
    output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues word reads to
// instruction memory and buffers {pc, inst} pairs in a small prefetch FIFO.
// A redirect flushes the FIFO and restarts fetch; a read already in flight
// is allowed to complete but its data is discarded.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CW       = $clog2(DEPTH + 1),
  localparam int         PW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  inst_fetch_queue_if.master     bus,
  output logic [1:0]             o_dbg_state,
  output logic [CW-1:0]          o_dbg_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // nothing outstanding
    S_WAIT = 2'd1,  // request outstanding, data wanted
    S_DROP = 2'd2   // request outstanding, data to be discarded
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_space_now;
  logic          w_space_after;
  logic [CW:0]   w_count_after;
  logic [31:0]   w_redirect_pc;
  logic          w_unused_bits;

  // The low two bits of a redirect target are forced to zero (word fetch).
  assign w_redirect_pc = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_bits = &{1'b0, bus.redirect_pc[1:0]};

  // Redirect wins over both push and pop in the same cycle.
  assign w_pop  = bus.inst_valid & bus.inst_ready & ~bus.redirect;
  assign w_push = bus.mem_ack & (r_state == S_WAIT) & ~bus.redirect;

  // Space checks: now (for a fresh request from IDLE) and after this cycle's
  // push/pop (for back-to-back requests from WAIT).
  assign w_space_now   = (r_count < CW'(DEPTH));
  assign w_count_after = {1'b0, r_count} + (CW+1)'(1) - (CW+1)'(w_pop);
  assign w_space_after = (w_count_after < (CW+1)'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic for the memory request FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!bus.redirect && w_space_now) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect)     w_next_state = bus.mem_ack ? S_IDLE : S_DROP;
        else if (bus.mem_ack) w_next_state = w_space_after ? S_WAIT : S_IDLE;
      end
      S_DROP: begin
        if (bus.mem_ack) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: a request is outstanding in every state but IDLE.
  always_comb begin
    bus.mem_req  = (r_state != S_IDLE);
    bus.mem_addr = r_req_addr;
    o_dbg_state  = r_state;
  end

  // Fetch PC and request address; req_addr only moves when a new request starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      if (bus.redirect)  r_fetch_pc <= w_redirect_pc;
      else if (w_push)   r_fetch_pc <= r_fetch_pc + 32'd4;

      if (r_state == S_IDLE && w_next_state == S_WAIT) r_req_addr <= r_fetch_pc;
      else if (w_push && w_space_after)                r_req_addr <= r_fetch_pc + 32'd4;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage of {pc, inst}; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_req_addr;
      r_inst_mem[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  // Head of queue presented combinationally to the datapath.
  always_comb begin
    bus.inst_valid = (r_count != '0);
    bus.inst_out   = r_inst_mem[r_rd_ptr];
    bus.inst_pc    = r_pc_mem[r_rd_ptr];
    o_dbg_count    = r_count;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: a randomized memory responder and
// datapath consumer, with a queue-based reference model of the expected
// instruction stream and request behaviour.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          CW       = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if bus();
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_count;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];       // expected head PCs, in delivery order
  logic [31:0] exp_inst_q[$];  // matching instruction words
  bit          m_out;          // a memory request should be outstanding
  bit          m_wanted;       // its data should be enqueued
  logic [31:0] m_addr;         // address of the outstanding request
  logic [31:0] m_fetch;        // next PC the front end should fetch

  // memory responder state
  bit r_busy;
  int r_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_inst_q.delete();
    m_out    = 1'b0;
    m_wanted = 1'b0;
    m_addr   = RESET_PC;
    m_fetch  = RESET_PC;
    r_busy   = 1'b0;
    r_lat    = 0;
  endtask

  task automatic check_outputs();
    check("mem_req", 32'(bus.mem_req), 32'(m_out));
    if (m_out) check("mem_addr", bus.mem_addr, m_addr);
    check("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    check("count", 32'(dbg_count), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check("inst_pc", bus.inst_pc, exp_q[0]);
      check("inst_out", bus.inst_out, exp_inst_q[0]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_req"},    32'(bus.mem_req), 32'd0);
    check({tag, " mem_addr"},   bus.mem_addr, RESET_PC);
    check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'd0);
    check({tag, " inst_out"},   bus.inst_out, 32'd0);
    check({tag, " inst_pc"},    bus.inst_pc, 32'd0);
    check({tag, " count"},      32'(dbg_count), 32'd0);
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge: check outputs, choose inputs, advance the model
  // over the coming rising edge, then move to the next falling edge.
  // rdy_mode: 0 stall, 1 ready, 2 random. redir_mode: 0 none, 1 force,
  // 2 only together with an ack and a pop, 3 random.
  task automatic step(input int rdy_mode, input int redir_mode, input logic [31:0] rpc,
                      input int lat_min, input int lat_max);
    bit          ack, rdy, redir, pop, push, out_n, new_req;
    logic [31:0] rp;
    int          size;
    check_outputs();

    ack = 1'b0;
    if (!r_busy && bus.mem_req) begin
      r_busy = 1'b1;
      r_lat  = int'($urandom_range(lat_max, lat_min));
    end
    if (r_busy) begin
      if (r_lat == 0) begin
        ack    = 1'b1;
        r_busy = 1'b0;
      end else begin
        r_lat--;
      end
    end

    rdy  = (rdy_mode == 2) ? ($urandom_range(1, 0) == 1) : (rdy_mode == 1);
    size = exp_q.size();
    case (redir_mode)
      1:       redir = 1'b1;
      2:       redir = ack && rdy && (size != 0);
      3:       redir = ($urandom_range(19, 0) == 0);
      default: redir = 1'b0;
    endcase
    rp = (redir_mode == 3) ? $urandom : rpc;

    bus.mem_ack     = ack;
    bus.mem_rdata   = ack ? mem_word(bus.mem_addr) : $urandom;
    bus.inst_ready  = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rp;

    // reference model over the coming edge
    pop  = (size != 0) && rdy && !redir;
    push = m_out && m_wanted && ack && !redir;
    new_req = 1'b0;
    if (m_out && !ack) begin
      out_n    = 1'b1;
      m_wanted = m_wanted && !redir;
    end else if (m_out && ack) begin
      out_n   = push ? (size + 1 - int'(pop) < DEPTH) : 1'b0;
      new_req = out_n;
    end else begin
      out_n   = !redir && (size < DEPTH);
      new_req = out_n;
    end

    if (redir) begin
      exp_q.delete();
      exp_inst_q.delete();
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        void'(exp_inst_q.pop_front());
      end
      if (push) begin
        exp_q.push_back(m_addr);
        exp_inst_q.push_back(mem_word(m_addr));
      end
    end

    if (redir)     m_fetch = rp & 32'hFFFF_FFFC;
    else if (push) m_fetch = m_fetch + 32'd4;

    if (new_req) begin
      m_addr   = m_fetch;
      m_wanted = 1'b1;
    end
    m_out = out_n;

    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    model_reset();

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // sequential fetch, single-cycle memory, datapath always ready
    repeat (16) step(1, 0, 32'h0, 0, 0);

    // backpressure: fill the queue, then drain
    repeat (10) step(0, 0, 32'h0, 0, 0);
    check("full count", 32'(dbg_count), DEPTH);
    check("full no req", 32'(bus.mem_req), 32'd0);
    repeat (8) step(1, 0, 32'h0, 0, 0);

    // redirect while a slow request is outstanding
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (bus.mem_req && r_busy && r_lat > 0) found = 1'b1;
      else step(1, 0, 32'h0, 3, 3);
    end
    check("reach wait for redirect", 32'(found), 32'd1);
    step(1, 1, 32'h0000_0103, 3, 3);
    check("redirect flush", 32'(bus.inst_valid), 32'd0);
    repeat (14) step(1, 0, 32'h0, 0, 0);

    // redirect coincident with ack and pop
    repeat (12) step(1, 2, 32'h0000_0200, 0, 0);
    repeat (4) step(1, 0, 32'h0, 0, 0);

    // 32-bit PC wrap
    step(1, 1, 32'hFFFF_FFF8, 0, 0);
    repeat (8) step(1, 0, 32'h0, 0, 0);

    // randomized traffic
    repeat (3000) step(2, 3, 32'h0, 0, 3);

    // asynchronous reset during an outstanding request, late ack during reset
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.mem_req && r_busy && r_lat > 0) found = 1'b1;
      else step(1, 0, 32'h0, 3, 3);
    end
    check("reach wait for reset", 32'(found), 32'd1);
    rst             = 1'b0;
    bus.redirect    = 1'b0;
    bus.inst_ready  = 1'b1;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = mem_word(bus.mem_addr);
    #1;
    check_reset_values("async reset");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("held reset");
    bus.mem_ack = 1'b0;
    rst         = 1'b1;
    model_reset();
    repeat (12) step(1, 0, 32'h0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch front end that sits directly upstream of the single-cycle `data_path`. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered, with their PCs, in a small prefetch FIFO that the datapath drains. A redirect from the datapath (taken branch/jump) flushes the queue and restarts fetch at the new PC; any read already in flight is discarded.

## Interface
- `DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000, fetch PC after reset (word aligned)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-low reset
- `mem_req` out 1: read request to instruction memory
- `mem_addr` out 32: byte address of request, word aligned
- `mem_ack` in 1: one-cycle pulse, `mem_rdata` valid
- `mem_rdata` in 32: instruction word
- `inst_valid` out 1: FIFO head valid
- `inst_out` out 32: head instruction
- `inst_pc` out 32: head PC
- `inst_ready` in 1: datapath consumes head this cycle
- `redirect` in 1: flush and restart fetch
- `redirect_pc` in 32: new fetch PC; bits [1:0] forced to 0

## Operation
- Registers: `fetch_pc` (next PC to request), `req_addr` (drives `mem_addr`), FIFO of {pc, inst} × DEPTH, `count` (clog2(DEPTH+1) bits), read/write pointers (wrap modulo DEPTH), FSM.
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, data wanted), DROP (request outstanding, data to be discarded). `mem_req` = (state != IDLE).
- `pop` = `inst_valid & inst_ready & ~redirect`. `push` = `mem_ack & state==WAIT & ~redirect`.
- IDLE: when `~redirect` and `count < DEPTH`, load `req_addr <= fetch_pc` and go to WAIT. `mem_ack` in IDLE is ignored.
- WAIT, ack without redirect: push {req_addr, mem_rdata} and set `fetch_pc <= fetch_pc + 4`. If `count + 1 - pop < DEPTH`, stay in WAIT with `req_addr <= fetch_pc + 4`; otherwise go to IDLE.
- WAIT, no ack, redirect: go to DROP.
- WAIT, ack and redirect in the same cycle: drop the data, go to IDLE.
- DROP, ack: discard the data, go to IDLE. `req_addr` holds until the ack.
- Redirect in any state:
  - `fetch_pc <= {redirect_pc[31:2],2'b00}`.
  - Count and pointers are cleared, so `inst_valid` = 0 next cycle.
  - Redirect takes priority over push and pop in the same cycle.
- `mem_addr` and `mem_req` stay stable while a request is outstanding; a request is never withdrawn.
- Same-cycle push and pop: `count` is unchanged. Push only occurs when `count < DEPTH`, so overflow is impossible by construction. Pop when empty is impossible because it is gated by `inst_valid`.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- `inst_valid` = (`count != 0`). `inst_out` and `inst_pc` are read combinationally from FIFO storage at the read pointer; their values are don't-care when invalid.

## Timing
- Reset values: `mem_req` 0, `mem_addr` RESET_PC, `inst_valid` 0, `inst_out`/`inst_pc` 0, `fetch_pc` RESET_PC, state IDLE, count 0.
- First `mem_req` is asserted on the first rising edge after `rst` deasserts.
- Ack at edge N: `inst_valid` is 1 after edge N, and the next request (if there is space) is presented in the same post-N cycle. With single-cycle memory this gives one instruction per cycle sustained.
- Redirect at edge N:
  - queue is empty after N;
  - from IDLE, or from WAIT with ack at N, the first new request goes out after edge N+1;
  - from DROP, it goes out one cycle after the stale ack.
- Reset mid-operation clears everything immediately, including an outstanding request. A late ack arriving after reset lands in IDLE and is ignored.

## Test plan
- Reset/sequential fetch, DEPTH=4, memory acks one cycle after req, `inst_ready`=1: `mem_addr` 0,4,8,…; `inst_pc`/`inst_out` match memory in order, one per cycle.
- Backpressure, `inst_ready`=0: exactly 4 requests (0x0–0xC), then `mem_req`=0 with count=4. Raise `inst_ready`: request 0x10 issues after the first pop.
- Redirect while WAIT (ack delayed 3 cycles), `redirect_pc`=0x103: `inst_valid` drops next cycle; stale data is not enqueued; next `mem_addr`=0x100; `inst_pc` 0x100, 0x104 follow.
- Redirect coincident with ack and pop: no push, no pop, queue empty next cycle, next request at the redirect PC.
- Wrap: RESET_PC=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset asserted mid-WAIT with ack arriving during reset: outputs return to reset values at once; no entry is enqueued; fetch restarts at RESET_PC.
